// File: rtl/core_ctrl_fsm.sv
// Multi-cycle control sequencer: fetch, decode/classify, execute, memory and
// write-back, with every datapath select/enable and a retired-instruction count.
module core_ctrl_fsm #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic        imem_ack,
  input  logic        dmem_ack,
  input  logic        branch_taken,
  output logic        imem_req,
  output logic        ir_we,
  output logic        pc_load_init,
  output logic [31:0] pc_init,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic        alu_a_sel,
  output logic        alu_b_sel,
  output logic [2:0]  imm_sel,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic        illegal,
  output logic        halted,
  output logic [31:0] instret
);
  typedef enum logic [2:0] {
    S_RST, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_MISC   = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  state_t      state_q, state_d;
  logic [6:0]  opcode_q, opcode_d;
  logic        illegal_q, illegal_d;
  logic [31:0] instret_q, instret_d;
  logic [6:0]  cur_op;

  function automatic logic [2:0] imm_of(input logic [6:0] op);
    case (op)
      OP_STORE:          imm_of = 3'd1;
      OP_BRANCH:         imm_of = 3'd2;
      OP_LUI, OP_AUIPC:  imm_of = 3'd3;
      OP_JAL:            imm_of = 3'd4;
      default:           imm_of = 3'd0;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_RST;
      opcode_q  <= 7'd0;
      illegal_q <= 1'b0;
      instret_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      illegal_q <= illegal_d;
      instret_q <= instret_d;
    end
  end

  // The opcode is only captured at the end of DECODE, so DECODE itself
  // classifies straight from the decoder.
  assign cur_op = (state_q == S_DECODE) ? opcode : opcode_q;

  always_comb begin
    state_d      = state_q;
    opcode_d     = opcode_q;
    illegal_d    = illegal_q;
    imem_req     = 1'b0;
    ir_we        = 1'b0;
    pc_load_init = 1'b0;
    pc_we        = 1'b0;
    pc_src       = 2'd0;
    alu_a_sel    = 1'b0;
    alu_b_sel    = 1'b0;
    imm_sel      = 3'd0;
    dmem_req     = 1'b0;
    dmem_we      = 1'b0;
    reg_we       = 1'b0;
    wb_sel       = 2'd0;
    if (state_q inside {S_DECODE, S_EXEC, S_MEM, S_WB}) imm_sel = imm_of(cur_op);
    case (state_q)
      S_RST: begin
        // Gated so the load strobe stays low while reset is still asserted.
        pc_load_init = rst_n;
        state_d      = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        opcode_d = opcode;
        case (opcode)
          OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE,
          OP_IMM, OP_OP, OP_MISC: state_d = S_EXEC;
          OP_SYSTEM:              state_d = S_HALT;
          default: begin
            state_d   = S_HALT;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_EXEC: begin
        alu_a_sel = (cur_op == OP_AUIPC) || (cur_op == OP_JAL) || (cur_op == OP_BRANCH);
        alu_b_sel = (cur_op != OP_OP);
        case (cur_op)
          OP_LOAD, OP_STORE: state_d = S_MEM;
          OP_BRANCH: begin
            pc_we   = 1'b1;
            pc_src  = branch_taken ? 2'd1 : 2'd0;
            state_d = S_FETCH;
          end
          OP_MISC: begin
            pc_we   = 1'b1;
            state_d = S_FETCH;
          end
          default: state_d = S_WB;
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (cur_op == OP_STORE);
        if (dmem_ack) begin
          if (cur_op == OP_STORE) begin
            pc_we   = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        reg_we = (rd != 5'd0);
        case (cur_op)
          OP_LOAD:          wb_sel = 2'd1;
          OP_JAL, OP_JALR:  wb_sel = 2'd2;
          OP_LUI:           wb_sel = 2'd3;
          default:          wb_sel = 2'd0;
        endcase
        pc_we   = 1'b1;
        pc_src  = (cur_op == OP_JAL) ? 2'd1 : (cur_op == OP_JALR) ? 2'd2 : 2'd0;
        state_d = S_FETCH;
      end
      default: state_d = S_HALT;
    endcase
    instret_d = instret_q + {31'd0, pc_we};
  end

  assign pc_init = RESET_PC;
  assign illegal = illegal_q;
  assign halted  = (state_q == S_HALT);
  assign instret = instret_q;
endmodule

// File: tb/tb_core_ctrl_fsm.sv
// Directed table-driven bench for core_ctrl_fsm plus hand-written sequences
// for reset-in-halt, asynchronous reset mid-MEM and instret wrap-around.
module tb_core_ctrl_fsm;
  logic        clk, rst_n;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic        imem_ack, dmem_ack, branch_taken;
  logic        imem_req, ir_we, pc_load_init, pc_we, alu_a_sel, alu_b_sel;
  logic        dmem_req, dmem_we, reg_we, illegal, halted;
  logic [1:0]  pc_src, wb_sel;
  logic [2:0]  imm_sel;
  logic [31:0] pc_init, instret;

  core_ctrl_fsm #(.RESET_PC(32'h0000_0100)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .rd(rd), .imem_ack(imem_ack),
    .dmem_ack(dmem_ack), .branch_taken(branch_taken), .imem_req(imem_req),
    .ir_we(ir_we), .pc_load_init(pc_load_init), .pc_init(pc_init), .pc_we(pc_we),
    .pc_src(pc_src), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
    .imm_sel(imm_sel), .dmem_req(dmem_req), .dmem_we(dmem_we), .reg_we(reg_we),
    .wb_sel(wb_sel), .illegal(illegal), .halted(halted), .instret(instret)
  );

  localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, JAL = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111, BR = 7'b1100011, LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011, ADDI = 7'b0010011, OPR = 7'b0110011;
  localparam logic [6:0] MISC = 7'b0001111, SYS = 7'b1110011, BAD = 7'h7F;

  typedef struct packed {
    logic ireq, irwe, pcl, pwe; logic [1:0] psrc; logic a, b; logic [2:0] imm;
    logic dreq, dwe, rwe; logic [1:0] wb; logic ill, hlt; logic [31:0] ir;
  } exp_t;

  typedef struct {
    logic [6:0] op; logic [4:0] rd; logic ia, da, bt; exp_t e;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0, n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t E(input logic ireq, irwe, pcl, pwe, input logic [1:0] psrc,
                             input logic a, b, input logic [2:0] imm,
                             input logic dreq, dwe, rwe, input logic [1:0] wb,
                             input logic ill, hlt, input logic [31:0] ir);
    E = '{ireq, irwe, pcl, pwe, psrc, a, b, imm, dreq, dwe, rwe, wb, ill, hlt, ir};
  endfunction

  task automatic chk(input exp_t e, input string nm);
    exp_t obs;
    obs = E(imem_req, ir_we, pc_load_init, pc_we, pc_src, alu_a_sel, alu_b_sel, imm_sel,
            dmem_req, dmem_we, reg_we, wb_sel, illegal, halted, instret);
    n_cmp++;
    if (obs !== e) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, obs, e);
    end
  endtask

  task automatic step(input logic [6:0] op, input logic [4:0] r, input logic ia, da, bt,
                      input exp_t e, input string nm);
    opcode = op; rd = r; imem_ack = ia; dmem_ack = da; branch_taken = bt;
    @(negedge clk);
    chk(e, nm);
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [6:0] op, input logic [4:0] r, input logic ia, da, bt,
                     input exp_t e);
    vec_t v;
    v.op = op; v.rd = r; v.ia = ia; v.da = da; v.bt = bt; v.e = e;
    tbl.push_back(v);
  endtask

  // FETCH with ack, and an idle DECODE carrying the given imm type
  function automatic exp_t F(input logic [31:0] ir);
    F = E(1,1,0,0,0,0,0,0,0,0,0,0,0,0,ir);
  endfunction
  function automatic exp_t D(input logic [2:0] imm, input logic [31:0] ir);
    D = E(0,0,0,0,0,0,0,imm,0,0,0,0,0,0,ir);
  endfunction

  initial begin
    rst_n = 1'b0; opcode = '0; rd = '0; imem_ack = 1'b0; dmem_ack = 1'b0; branch_taken = 1'b0;

    // ADDI rd=5
    add(ADDI,5,0,0,0, E(0,0,1,0,0,0,0,0,0,0,0,0,0,0,0));
    add(ADDI,5,1,0,0, F(0));
    add(ADDI,5,0,0,0, D(0,0));
    add(ADDI,5,0,0,0, E(0,0,0,0,0,0,1,0,0,0,0,0,0,0,0));
    add(ADDI,5,0,0,0, E(0,0,0,1,0,0,0,0,0,0,1,0,0,0,0));
    // LOAD rd=7, dmem_ack after 3 wait cycles
    add(LD,7,1,0,0, F(1));
    add(LD,7,0,0,0, D(0,1));
    add(LD,7,0,0,0, E(0,0,0,0,0,0,1,0,0,0,0,0,0,0,1));
    for (int i = 0; i < 3; i++) add(LD,7,0,0,0, E(0,0,0,0,0,0,0,0,1,0,0,0,0,0,1));
    add(LD,7,0,1,0, E(0,0,0,0,0,0,0,0,1,0,0,0,0,0,1));
    add(LD,7,0,0,0, E(0,0,0,1,0,0,0,0,0,0,1,1,0,0,1));
    // BRANCH taken (one fetch wait, stray dmem_ack), then not taken
    add(BR,9,0,1,0, E(1,0,0,0,0,0,0,0,0,0,0,0,0,0,2));
    add(BR,9,1,0,0, F(2));
    add(BR,9,0,0,0, D(2,2));
    add(BR,9,0,0,1, E(0,0,0,1,1,1,1,2,0,0,0,0,0,0,2));
    add(BR,9,1,0,0, F(3));
    add(BR,9,0,0,0, D(2,3));
    add(BR,9,0,0,0, E(0,0,0,1,0,1,1,2,0,0,0,0,0,0,3));
    // STORE with both acks high in MEM
    add(ST,0,1,0,0, F(4));
    add(ST,0,0,0,0, D(1,4));
    add(ST,0,0,0,0, E(0,0,0,0,0,0,1,1,0,0,0,0,0,0,4));
    add(ST,0,1,1,0, E(0,0,0,1,0,0,0,1,1,1,0,0,0,0,4));
    // JAL rd=0
    add(JAL,0,1,0,0, F(5));
    add(JAL,0,0,0,0, D(4,5));
    add(JAL,0,0,0,0, E(0,0,0,0,0,1,1,4,0,0,0,0,0,0,5));
    add(JAL,0,0,0,0, E(0,0,0,1,1,0,0,4,0,0,0,2,0,0,5));
    // LUI rd=1
    add(LUI,1,1,0,0, F(6));
    add(LUI,1,0,0,0, D(3,6));
    add(LUI,1,0,0,0, E(0,0,0,0,0,0,1,3,0,0,0,0,0,0,6));
    add(LUI,1,0,0,0, E(0,0,0,1,0,0,0,3,0,0,1,3,0,0,6));
    // JALR rd=2
    add(JALR,2,1,0,0, F(7));
    add(JALR,2,0,0,0, D(0,7));
    add(JALR,2,0,0,0, E(0,0,0,0,0,0,1,0,0,0,0,0,0,0,7));
    add(JALR,2,0,0,0, E(0,0,0,1,2,0,0,0,0,0,1,2,0,0,7));
    // OP rd=3
    add(OPR,3,1,0,0, F(8));
    add(OPR,3,0,0,0, D(0,8));
    add(OPR,3,0,0,0, E(0,0,0,0,0,0,0,0,0,0,0,0,0,0,8));
    add(OPR,3,0,0,0, E(0,0,0,1,0,0,0,0,0,0,1,0,0,0,8));
    // AUIPC rd=4
    add(AUIPC,4,1,0,0, F(9));
    add(AUIPC,4,0,0,0, D(3,9));
    add(AUIPC,4,0,0,0, E(0,0,0,0,0,1,1,3,0,0,0,0,0,0,9));
    add(AUIPC,4,0,0,0, E(0,0,0,1,0,0,0,3,0,0,1,0,0,0,9));
    // MISC-MEM
    add(MISC,0,1,0,0, F(10));
    add(MISC,0,0,0,0, D(0,10));
    add(MISC,0,0,0,0, E(0,0,0,1,0,0,1,0,0,0,0,0,0,0,10));
    // illegal opcode -> sticky HALT
    add(BAD,0,1,0,0, F(11));
    add(BAD,0,0,0,0, D(0,11));
    add(BAD,0,1,1,0, E(0,0,0,0,0,0,0,0,0,0,0,0,1,1,11));
    add(BAD,0,1,1,0, E(0,0,0,0,0,0,0,0,0,0,0,0,1,1,11));

    // reset state
    #12;
    chk(E(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0), "reset_outputs");
    n_cmp++;
    if (pc_init !== 32'h100) begin
      n_bad++;
      $display("FAIL pc_init: got %h want %h", pc_init, 32'h100);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    foreach (tbl[i]) step(tbl[i].op, tbl[i].rd, tbl[i].ia, tbl[i].da, tbl[i].bt, tbl[i].e,
                          $sformatf("vec%0d", i));

    // reset out of HALT clears illegal/instret; SYSTEM halts without illegal
    rst_n = 1'b0; #1;
    chk(E(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0), "halt_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(SYS,0,0,0,0, E(0,0,1,0,0,0,0,0,0,0,0,0,0,0,0), "sys_rst");
    step(SYS,0,1,0,0, F(0), "sys_fetch");
    step(SYS,0,0,0,0, D(0,0), "sys_decode");
    step(SYS,0,1,0,0, E(0,0,0,0,0,0,0,0,0,0,0,0,0,1,0), "sys_halt");

    // asynchronous reset while a load waits in MEM
    rst_n = 1'b0; @(posedge clk); #1; rst_n = 1'b1;
    step(LD,6,0,0,0, E(0,0,1,0,0,0,0,0,0,0,0,0,0,0,0), "mr_rst");
    step(LD,6,1,0,0, F(0), "mr_fetch");
    step(LD,6,0,0,0, D(0,0), "mr_decode");
    step(LD,6,0,0,0, E(0,0,0,0,0,0,1,0,0,0,0,0,0,0,0), "mr_exec");
    step(LD,6,0,0,0, E(0,0,0,0,0,0,0,0,1,0,0,0,0,0,0), "mr_mem");
    #2 rst_n = 1'b0;
    #1 chk(E(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0), "mr_async_drop");
    @(posedge clk); #1; rst_n = 1'b1;
    step(LD,6,0,0,0, E(0,0,1,0,0,0,0,0,0,0,0,0,0,0,0), "mr_restart");

    // instret wrap: preload all-ones across an idle edge, then retire MISC-MEM
    force dut.instret_q = 32'hFFFF_FFFF;
    step(MISC,0,0,0,0, E(1,0,0,0,0,0,0,0,0,0,0,0,0,0,32'hFFFF_FFFF), "wr_wait");
    release dut.instret_q;
    step(MISC,0,1,0,0, F(32'hFFFF_FFFF), "wr_fetch");
    step(MISC,0,0,0,0, D(0,32'hFFFF_FFFF), "wr_decode");
    step(MISC,0,0,0,0, E(0,0,0,1,0,0,1,0,0,0,0,0,0,0,32'hFFFF_FFFF), "wr_exec");
    step(MISC,0,0,0,0, E(1,0,0,0,0,0,0,0,0,0,0,0,0,0,0), "wr_wrapped");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
